// File: rtl/program_ram.sv
// 256x8 program/data RAM on the CPU bus, with a valid/ready boot loader that
// holds the CPU in reset while it fills memory from address 0.
module program_ram #(
    parameter int ADDR_W      = 8,
    parameter int RELEASE_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              c_ri,
    input  logic              c_ro,
    inout  wire  [7:0]        bus,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_reset,
    output logic [ADDR_W:0]   load_count,
    output logic              load_err
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {LOAD, RELEASE, RUN} state_t;

    state_t          state_q;
    logic [3:0]      rel_q;
    logic [ADDR_W:0] count_q;
    logic            err_q;
    logic            cpu_reset_q;
    logic            ready_q;
    logic [7:0]      mem_q [DEPTH];

    logic beat;
    logic lastAddr;
    logic runWe;
    logic runRd;

    assign beat     = (state_q == LOAD) && ready_q && load_valid;
    assign lastAddr = &count_q[ADDR_W-1:0];
    // A simultaneous read wins over a write so the RAM never samples its own drive.
    assign runWe    = (state_q == RUN) && c_ri && !c_ro;
    assign runRd    = (state_q == RUN) && c_ro;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            rel_q       <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (beat) begin
                        count_q <= count_q + 1'b1;
                        if (load_last) begin
                            state_q <= RELEASE;
                            rel_q   <= 4'(RELEASE_CYC);
                            ready_q <= 1'b0;
                        end else if (lastAddr) begin
                            // Image longer than the RAM: lock out until reset.
                            err_q   <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                RELEASE: begin
                    if (rel_q == 4'd1) begin
                        state_q     <= RUN;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        rel_q <= rel_q - 4'd1;
                    end
                end
                RUN: begin
                    if (load_start) begin
                        state_q     <= LOAD;
                        cpu_reset_q <= 1'b1;
                        ready_q     <= 1'b1;
                        count_q     <= '0;
                        err_q       <= 1'b0;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    // Memory is deliberately left out of reset so a warm reset keeps the image.
    always_ff @(posedge clk) begin
        if (beat && !reset) begin
            mem_q[count_q[ADDR_W-1:0]] <= load_data;
        end else if (runWe) begin
            mem_q[addr] <= bus;
        end
    end

    assign bus        = runRd ? mem_q[addr] : 8'hzz;
    assign load_ready = ready_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_count = count_q;
    assign load_err   = err_q;
endmodule

// File: tb/tb_program_ram.sv
// Scoreboard bench for program_ram: stimulus queues expectations per cycle and
// a negedge monitor compares them against the DUT outputs.
module tb_program_ram;
    localparam int K_BUS = 0, K_COUNT = 1, K_ERR = 2, K_CPURST = 3, K_READY = 4;

    typedef struct {
        int          when;
        int          kind;
        logic [15:0] exp;
        string       name;
    } chk_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] addr = 8'h00;
    logic       c_ri = 1'b0;
    logic       c_ro = 1'b0;
    wire  [7:0] bus;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_last = 1'b0;
    logic       load_ready;
    logic       cpu_reset;
    logic [8:0] load_count;
    logic       load_err;

    logic       tbDrive = 1'b0;
    logic [7:0] tbBus = 8'h00;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    chk_t scoreQ[$];

    logic [7:0] bootBytes [4] = '{8'h1E, 8'h2F, 8'hE0, 8'hF0};
    logic       stallValid [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] stallData [5] = '{8'hA1, 8'hEE, 8'hEE, 8'hB2, 8'hC3};
    logic       stallLast [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int         stallCount [5] = '{0, 1, 1, 1, 2};

    assign bus = tbDrive ? tbBus : 8'hzz;

    program_ram #(.ADDR_W(8), .RELEASE_CYC(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .c_ri       (c_ri),
        .c_ro       (c_ro),
        .bus        (bus),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_reset  (cpu_reset),
        .load_count (load_count),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: everything queued for the current cycle is compared at the falling edge.
    always @(negedge clk) begin
        chk_t        c;
        logic [15:0] act;
        while (scoreQ.size() > 0 && scoreQ[0].when <= cyc) begin
            c = scoreQ.pop_front();
            case (c.kind)
                K_BUS:    act = {8'h00, bus};
                K_COUNT:  act = {7'h00, load_count};
                K_ERR:    act = {15'h0, load_err};
                K_CPURST: act = {15'h0, cpu_reset};
                default:  act = {15'h0, load_ready};
            endcase
            compared++;
            if (act !== c.exp) begin
                mismatched++;
                $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", c.name, cyc, act, c.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic last);
        load_valid = valid;
        load_data  = data;
        load_last  = last;
    endtask

    task automatic checkOutput(input int kind, input logic [15:0] exp, input string name);
        chk_t c;
        c.when = cyc;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        scoreQ.push_back(c);
    endtask

    task automatic readCheck(input logic [7:0] a, input logic [7:0] exp, input string name);
        addr = a;
        c_ro = 1'b1;
        checkOutput(K_BUS, {8'h00, exp}, name);
        tick();
        c_ro = 1'b0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        checkOutput(K_CPURST, 16'd1, "reset_cpu_reset");
        checkOutput(K_READY, 16'd1, "reset_ready");
        checkOutput(K_COUNT, 16'd0, "reset_count");
        checkOutput(K_ERR, 16'd0, "reset_err");
        reset = 1'b0;
        tick();

        // Boot load of four bytes, last on the fourth.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, bootBytes[i], i == 3);
            checkOutput(K_READY, 16'd1, "boot_ready");
            checkOutput(K_COUNT, 16'(i), "boot_count");
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput(K_COUNT, 16'd4, "boot_final_count");
        checkOutput(K_CPURST, 16'd1, "boot_release_cyc1");
        checkOutput(K_READY, 16'd0, "boot_release_ready");
        tick();
        checkOutput(K_CPURST, 16'd1, "boot_release_cyc2");
        tick();
        checkOutput(K_CPURST, 16'd0, "boot_run_entered");
        checkOutput(K_COUNT, 16'd4, "boot_count_held");
        tick();

        // Stalled handshake: only valid cycles write, last on an idle cycle is ignored.
        pulseReset();
        checkOutput(K_COUNT, 16'd0, "stall_reset_count");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(stallValid[i], stallData[i], stallLast[i]);
            checkOutput(K_READY, 16'd1, "stall_ready");
            checkOutput(K_COUNT, 16'(stallCount[i]), "stall_count");
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput(K_COUNT, 16'd3, "stall_final_count");
        tick();
        tick();
        checkOutput(K_CPURST, 16'd0, "stall_run");
        tick();
        readCheck(8'h00, 8'hA1, "stall_mem0");
        readCheck(8'h01, 8'hB2, "stall_mem1");
        readCheck(8'h02, 8'hC3, "stall_mem2");
        readCheck(8'h03, 8'hF0, "stall_mem3_kept");

        // RUN write, bus release with c_ro low, read-back, and read-over-write priority.
        addr = 8'h10; tbBus = 8'h5A; tbDrive = 1'b1; c_ri = 1'b1;
        tick();
        c_ri = 1'b0; tbDrive = 1'b0;
        addr = 8'h03; tbBus = 8'h0F; tbDrive = 1'b1;
        checkOutput(K_BUS, 16'h000F, "run_bus_released");
        tick();
        tbDrive = 1'b0;
        readCheck(8'h10, 8'h5A, "run_write_readback");
        addr = 8'h10; c_ri = 1'b1; c_ro = 1'b1;
        checkOutput(K_BUS, 16'h005A, "run_ri_ro_read");
        tick();
        c_ri = 1'b0; c_ro = 1'b0;
        readCheck(8'h10, 8'h5A, "run_ri_ro_nowrite");

        // Overflow: 256 bytes without last, then a 257th that must be refused.
        pulseReset();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 8'((i + 3) & 255), 1'b0);
            checkOutput(K_READY, 16'd1, "ovf_ready");
            tick();
        end
        applyStimulus(1'b1, 8'h77, 1'b0);
        checkOutput(K_ERR, 16'd1, "ovf_err");
        checkOutput(K_READY, 16'd0, "ovf_ready_low");
        checkOutput(K_COUNT, 16'd256, "ovf_count");
        checkOutput(K_CPURST, 16'd1, "ovf_cpu_reset");
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput(K_COUNT, 16'd256, "ovf_no_more_beats");
            checkOutput(K_READY, 16'd0, "ovf_ready_stays_low");
            checkOutput(K_CPURST, 16'd1, "ovf_cpu_held");
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();

        // Exact fill: last on byte 256 is legal.
        pulseReset();
        checkOutput(K_ERR, 16'd0, "fill_reset_err");
        checkOutput(K_COUNT, 16'd0, "fill_reset_count");
        checkOutput(K_READY, 16'd1, "fill_reset_ready");
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 8'((i * 7 + 1) & 255), i == 255);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput(K_COUNT, 16'd256, "fill_count");
        checkOutput(K_ERR, 16'd0, "fill_no_err");
        checkOutput(K_CPURST, 16'd1, "fill_release");
        tick();
        tick();
        checkOutput(K_CPURST, 16'd0, "fill_run");
        tick();
        readCheck(8'h00, 8'h01, "fill_mem00");
        readCheck(8'h02, 8'h0F, "fill_mem02");
        readCheck(8'h80, 8'h81, "fill_mem80");
        readCheck(8'hFF, 8'hFA, "fill_memFF");

        // Reload request coinciding with a CPU write, then reset in mid-load.
        addr = 8'h20; tbBus = 8'h3C; tbDrive = 1'b1; c_ri = 1'b1; load_start = 1'b1;
        checkOutput(K_CPURST, 16'd0, "reload_pre_run");
        tick();
        c_ri = 1'b0; load_start = 1'b0; tbDrive = 1'b0;
        checkOutput(K_CPURST, 16'd1, "reload_cpu_reset");
        checkOutput(K_COUNT, 16'd0, "reload_count_clr");
        checkOutput(K_READY, 16'd1, "reload_ready");
        checkOutput(K_ERR, 16'd0, "reload_err_clr");
        applyStimulus(1'b1, 8'h91, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h92, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput(K_COUNT, 16'd2, "reload_two_beats");
        pulseReset();
        checkOutput(K_COUNT, 16'd0, "midload_reset_count");
        checkOutput(K_CPURST, 16'd1, "midload_reset_cpu");
        checkOutput(K_READY, 16'd1, "midload_reset_ready");
        applyStimulus(1'b1, 8'h91, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        checkOutput(K_CPURST, 16'd0, "midload_run");
        tick();
        readCheck(8'h00, 8'h91, "midload_mem0");
        readCheck(8'h01, 8'h92, "midload_mem1_kept");
        readCheck(8'h20, 8'h3C, "reload_write_landed");
        readCheck(8'h10, 8'h71, "midload_mem10_kept");

        tick();
        tick();
        if (scoreQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", scoreQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/program_ram.md
Name: program_ram

Overview:
- 256x8 program/data RAM on the CPU's shared 8-bit bus, addressed by the CPU's memory address register output.
- Serves CPU reads (RAM out) and writes (RAM in) during normal execution.
- Contains a byte-stream boot loader: it holds the CPU in reset, fills RAM from address 0 with a valid/ready stream, then releases the CPU.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W.
- RELEASE_CYC, 2, cycles cpu_reset stays high after the last load byte is written (range 1..15).

Ports:
- clk  input  1  system clock; every state change happens on its rising edge.
- reset  input  1  synchronous, active-high.
- addr  input  ADDR_W  CPU memory address register value.
- c_ri  input  1  CPU write strobe (RAM in).
- c_ro  input  1  CPU read strobe (RAM out).
- bus  inout  8  shared CPU bus.
- load_start  input  1  one-cycle request to re-enter loading from RUN.
- load_valid  input  1  a load byte is presented.
- load_data  input  8  the load byte.
- load_last  input  1  qualifies load_data as the final byte of the image.
- load_ready  output  1  loader accepts a byte this cycle.
- cpu_reset  output  1  reset to the CPU and cycle counter.
- load_count  output  ADDR_W+1  number of bytes written by the current or most recent load.
- load_err  output  1  sticky overflow flag: the image was longer than the RAM depth.

Behaviour:
- States: LOAD, RELEASE, RUN.
- Reset values: state=LOAD, load_count=0, load_err=0, cpu_reset=1, load_ready=1, bus=Z. RAM contents are not cleared by reset.
- LOAD state:
  - cpu_reset=1; load_ready=1 unless load_err=1.
  - Handshake beat = load_valid && load_ready. On each beat: mem[load_count[ADDR_W-1:0]] <= load_data; load_count += 1.
  - Beat with load_last=1: byte written, then state -> RELEASE with a release counter set to RELEASE_CYC.
  - Beat that makes load_count = 2**ADDR_W with load_last=0: load_err <= 1; no further writes; load_ready=0; the FSM stays in LOAD until reset. A byte landing exactly on the last address with load_last=1 is not an error.
  - c_ri and c_ro are ignored; bus is never driven.
  - load_valid=0 stalls indefinitely with no timeout.
- RELEASE state:
  - cpu_reset=1, load_ready=0.
  - The counter decrements each cycle. At 1, state -> RUN. cpu_reset therefore stays high exactly RELEASE_CYC cycles after the last-beat edge.
- RUN state:
  - cpu_reset=0, load_ready=0.
  - Read: bus = mem[addr] whenever c_ro=1. The read is combinational (asynchronous) from addr, with no clock latency, so the CPU can capture it on its opposite clock phase. Otherwise bus=Z.
  - Write: c_ri=1 at a rising clk edge writes mem[addr] <= bus.
  - c_ri and c_ro both high: the write is ignored and the read is performed, so the block never samples its own drive.
  - load_start=1: state -> LOAD at the next edge, cpu_reset=1 from that edge, load_count <= 0, load_err <= 0. A c_ri write in that same cycle still completes.
- Reset in any state, including mid-load: returns to LOAD with load_count=0. Bytes already written stay in RAM.
- load_count holds its final value through RELEASE and RUN.
- Addresses wrap modulo depth; addr is always in range by width.
- The bus may be driven only in RUN with c_ro=1. This is a bench assertion.

Test Plan:
- Boot load: reset, then stream 0x1E,0x2F,0xE0,0xF0 with last on 0xF0 -> mem[0..3] = those bytes; load_count=4; cpu_reset falls exactly 2 cycles after the last beat; state RUN.
- Stall and handshake: load_valid toggled 1/0/0/1 with 3 bytes -> exactly 3 writes at addresses 0,1,2; no write on invalid cycles; load_ready stays 1 throughout LOAD.
- RUN access: addr=0x03, c_ro=1 -> bus=0xF0 in the same cycle. Then addr=0x10, bus driven to 0x5A, c_ri=1 for one edge -> a later read of 0x10 returns 0x5A. With c_ro=0, bus=Z.
- Overflow: 257 bytes with no load_last -> load_err=1 after byte 256; load_ready=0; mem[0] not overwritten; cpu_reset stays 1.
- Exact fill: 256 bytes with load_last on byte 256 -> load_err=0; load_count=256; RUN is entered.
- Reload and mid-load reset: in RUN, pulse load_start together with c_ri to addr 0x20 -> the write lands, cpu_reset=1 next cycle, load_count=0. After 2 beats assert reset -> load_count=0, state LOAD, mem[0..1] hold the new bytes.
